// File: rtl/fc_argmax_reader.sv
// fc_argmax_reader: streaming argmax over one frame of signed class scores.
// Accepts one score per valid/ready beat, tracks the running maximum and the
// index where it first appeared, and presents one registered result per
// frame. Frames whose length differs from NUM_CLASSES are flagged via m_err.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   s_valid/s_ready     score stream handshake (s_ready high only in SCAN)
//   s_data              signed score, DATA_W bits
//   s_last              final beat of a frame
//   m_valid/m_ready     result handshake
//   m_class             index of the maximum score (lowest index on ties)
//   m_score             maximum score value
//   m_err               frame length was not NUM_CLASSES
module fc_argmax_reader #(
  parameter int unsigned NUM_CLASSES = 10,
  parameter int unsigned DATA_W      = 16,
  parameter int unsigned IDX_W       = $clog2(NUM_CLASSES)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_last,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [IDX_W-1:0]  m_class,
  output logic [DATA_W-1:0] m_score,
  output logic              m_err
);

  localparam int unsigned CNT_W = IDX_W + 1;
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(NUM_CLASSES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NUM_CLASSES - 1);

  typedef enum logic {SCAN, EMIT} state_t;

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic [DATA_W-1:0] best_score;
  logic [IDX_W-1:0]  best_idx;
  logic              err;

  logic              accept;
  logic [DATA_W-1:0] nxt_score;
  logic [IDX_W-1:0]  nxt_idx;
  logic              nxt_err;

  // Ready is a decode of the state register only.
  assign s_ready = (state == SCAN);
  assign accept  = s_valid && s_ready;

  // Running-max / error update for the beat currently presented.
  always_comb begin
    nxt_score = best_score;
    nxt_idx   = best_idx;
    nxt_err   = err;
    if (cnt == '0) begin
      // First beat seeds the maximum and starts a clean error flag.
      nxt_score = s_data;
      nxt_idx   = '0;
      nxt_err   = 1'b0;
    end else if (cnt < CNT_MAX && $signed(s_data) > $signed(best_score)) begin
      // Strictly greater only, so ties keep the earliest index.
      nxt_score = s_data;
      nxt_idx   = cnt[IDX_W-1:0];
    end
    if (cnt >= CNT_MAX) begin
      nxt_err = 1'b1;
    end
    if (s_last && cnt != CNT_LAST) begin
      nxt_err = 1'b1;
    end
  end

  // Frame FSM, counter, running max and registered result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= SCAN;
      cnt        <= '0;
      best_score <= '0;
      best_idx   <= '0;
      err        <= 1'b0;
      m_valid    <= 1'b0;
      m_class    <= '0;
      m_score    <= '0;
      m_err      <= 1'b0;
    end else begin
      case (state)
        SCAN: begin
          if (accept) begin
            best_score <= nxt_score;
            best_idx   <= nxt_idx;
            err        <= nxt_err;
            if (s_last) begin
              state   <= EMIT;
              m_valid <= 1'b1;
              m_class <= nxt_idx;
              m_score <= nxt_score;
              m_err   <= nxt_err;
              cnt     <= '0;
            end else if (cnt < CNT_MAX) begin
              // Saturate so overlong frames keep reporting out-of-range beats.
              cnt <= cnt + CNT_W'(1);
            end
          end
        end
        EMIT: begin
          if (m_ready) begin
            state   <= SCAN;
            m_valid <= 1'b0;
          end
        end
        default: state <= SCAN;
      endcase
    end
  end

endmodule

// File: doc/fc_argmax_reader.md
# fc_argmax_reader

Streaming consumer for the fully connected layer's class scores. It accepts one signed score per beat over a valid/ready stream, tracks the running maximum and its index, and presents the winning class and score as one registered result per frame. It sits between the final fully connected layer and the classification result output. It also flags malformed frames whose length differs from NUM_CLASSES.

## Interface
- NUM_CLASSES, 10: scores per frame; must be 2 or more.
- DATA_W, 16: score width, two's-complement signed.
- IDX_W, $clog2(NUM_CLASSES): class index width.

- clk  in  1  single clock; all logic is rising-edge.
- rst_n  in  1  asynchronous active-low reset.
- s_valid  in  1  score beat valid.
- s_ready  out  1  block can accept a beat.
- s_data  in  DATA_W  signed score.
- s_last  in  1  marks the final beat of a frame.
- m_valid  out  1  result valid.
- m_ready  in  1  downstream accepts the result.
- m_class  out  IDX_W  index of the maximum score.
- m_score  out  DATA_W  maximum score value.
- m_err  out  1  frame length was not NUM_CLASSES; qualified by m_valid.

## Operation
- Two states: SCAN and EMIT. Reset state is SCAN.
- A beat is accepted when s_valid and s_ready are both high on a rising edge. s_ready is 1 in SCAN and 0 in EMIT.
- A beat counter, IDX_W+1 bits, starts at 0 and increments on each accepted beat. It saturates at NUM_CLASSES.
- Running maximum update:
  - Beat 0 always loads best_score=s_data and best_idx=0.
  - A later beat with index below NUM_CLASSES replaces best only if s_data is strictly greater under a signed compare. Ties therefore keep the lowest index.
  - Beats with index NUM_CLASSES or higher are not compared.
- Error flag:
  - Set when a beat arrives with index NUM_CLASSES or higher.
  - Set when s_last arrives on a beat whose index is not NUM_CLASSES-1.
  - Cleared at the start of each frame.
- Frame end is the accepted beat with s_last=1. On that edge:
  - The state goes to EMIT.
  - m_class, m_score and m_err load the final values, including that last beat's own compare and error check.
  - The counter returns to 0.
- EMIT state:
  - m_valid=1 and all outputs are held stable until m_ready=1.
  - On the edge where m_valid and m_ready are both high, the state goes to SCAN and m_valid falls.
- Frame boundaries are defined only by s_last. An overlong frame never ends until s_last arrives.
- A one-beat frame (s_last on beat 0) produces class 0, that score, and m_err=1.
- Reset values: state SCAN, s_ready 1, m_valid 0, m_class 0, m_score 0, m_err 0, counter 0, best_score 0, best_idx 0.
- Asserting rst_n low mid-frame or during EMIT discards all state immediately. No result is emitted for the interrupted frame.

## Timing
- Latency: the last beat is accepted at edge N, and m_valid is high from edge N to the edge where m_ready is sampled high.
- With m_ready held high, the result is accepted at edge N+1. s_ready returns at edge N+1, so the next frame's beat 0 can be accepted at edge N+2.
- Maximum throughput is one frame per NUM_CLASSES+1 cycles.
- s_ready is a pure decode of registered state, with no combinational path from m_ready or s_valid.
- m_* outputs are registers only.
- The input side tolerates s_valid gaps of any length. The counter and maximum hold while no beat is accepted.
- Under backpressure in EMIT, s_valid may stay high. No beat is consumed, and s_data must stay stable per the stream rules.

## Test plan
- **Basic frame:** scores 3,-5,7,2,7,0,1,-1,4,6 with s_last on beat 9, m_ready=1.
  - Required: m_class=2, m_score=7, m_err=0, m_valid for one cycle.
  - Required: the next frame's beat 0 is accepted two edges after the last beat.
- **All negative with backpressure:** all scores -32768 except beat 9 = -1, and m_ready held 0 for 5 cycles.
  - Required: m_class=9, m_score=0xFFFF, outputs stable for 5 cycles.
  - Required: s_ready=0 throughout EMIT.
- **Ties:** all ten scores equal to 100.
  - Required: m_class=0, m_score=100.
- **Length errors:**
  - s_last on beat 4 with scores 1,2,9,3,4 → m_class=2, m_score=9, m_err=1.
  - A 12-beat frame with a score of 50 at beat 11 and a maximum of 8 at beat 3 → m_class=3, m_score=8, m_err=1.
- **Sparse valid:** frame 1 of 0..9 with s_valid toggling 1/0 every cycle.
  - Required: m_class=9, m_score=9, identical to the gap-free case.
- **Reset mid-frame:** pull rst_n low after beat 5 of a frame, then release it.
  - Required: m_valid=0 and all outputs 0 immediately.
  - Required: a fresh 10-beat frame afterwards returns the correct result with m_err=0.
